// File: rtl/flash_boot_loader.sv
// Power-up loader: reads an image from SPI flash (READ 0x03) into SRAM while holding the CPU,
// then hands the flash pins to the CPU-side SPI block.
module flash_boot_loader #(
    parameter logic [23:0] FLASH_BASE = 24'h010000,
    parameter logic [18:0] SRAM_BASE  = 19'h00000,
    parameter int          LENGTH     = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reload,
    input  logic        cpu_flash_cs_n,
    input  logic        cpu_flash_clk,
    input  logic        cpu_flash_di,
    output logic        flash_cs_n,
    output logic        flash_clk,
    output logic        flash_di,
    input  logic        flash_do,
    output logic        mem_wr_req,
    output logic [18:0] mem_addr,
    output logic [7:0]  mem_data,
    input  logic        mem_wr_ack,
    output logic        boot_done,
    output logic        cpu_hold
);

    // state  | meaning
    // IDLE   | one cycle, CS high, load counters and command word
    // CMD    | shift out {8'h03, FLASH_BASE}, 32 bits
    // RX     | shift in one byte, DI low
    // WR     | SRAM write pending, SCLK held low (flash clock stretched)
    // DONE   | copy finished, pins belong to the CPU
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RX,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [18:0] LAST_BYTE = 19'(LENGTH - 1);

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [6:0]  rx_q, rx_d;
    logic [18:0] byte_cnt_q, byte_cnt_d;
    logic [18:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        ld_cs_n, ld_clk, ld_di, wr_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_q       <= '0;
            byte_cnt_q <= '0;
            addr_q     <= SRAM_BASE;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_q       <= rx_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_d       = rx_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ld_cs_n    = 1'b1;
        ld_clk     = 1'b0;
        ld_di      = 1'b0;
        wr_req     = 1'b0;
        case (state_q)
            S_IDLE: begin
                byte_cnt_d = '0;
                addr_d     = SRAM_BASE;
                shift_d    = {8'h03, FLASH_BASE};
                bit_cnt_d  = 5'd31;
                phase_d    = 1'b0;
                state_d    = S_CMD;
            end
            S_CMD: begin
                ld_cs_n = 1'b0;
                ld_clk  = phase_q;
                ld_di   = shift_q[31];
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd7;
                        state_d   = S_RX;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                        shift_d   = {shift_q[30:0], 1'b0};
                    end
                end
            end
            S_RX: begin
                ld_cs_n = 1'b0;
                ld_clk  = phase_q;
                phase_d = ~phase_q;
                // Sample on the edge that ends the SCLK-high phase.
                if (phase_q) begin
                    rx_d = {rx_q[5:0], flash_do};
                    if (bit_cnt_q == 5'd0) begin
                        data_d  = {rx_q, flash_do};
                        state_d = S_WR;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
            end
            S_WR: begin
                ld_cs_n = 1'b0;
                wr_req  = 1'b1;
                if (mem_wr_ack) begin
                    addr_d     = addr_q + 19'd1;
                    byte_cnt_d = byte_cnt_q + 19'd1;
                    bit_cnt_d  = 5'd7;
                    phase_d    = 1'b0;
                    state_d    = (byte_cnt_q == LAST_BYTE) ? S_DONE : S_RX;
                end
            end
            S_DONE: begin
                if (reload) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Loader CS is already high in DONE, so the handover cannot glitch CS low.
    assign boot_done  = (state_q == S_DONE);
    assign cpu_hold   = ~boot_done;
    assign flash_cs_n = boot_done ? cpu_flash_cs_n : ld_cs_n;
    assign flash_clk  = boot_done ? cpu_flash_clk  : ld_clk;
    assign flash_di   = boot_done ? cpu_flash_di   : ld_di;
    assign mem_wr_req = wr_req;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;

endmodule

// File: tb/tb_flash_boot_loader.sv
// Self-checking bench for flash_boot_loader: flash and SRAM-arbiter models, vector table,
// random images/ack delays, and hand sequences for reset, reload, handover and address wrap.
`timescale 1ns/1ps
module tb_flash_boot_loader;

    logic       clk = 1'b0;
    logic [1:0] rst_n = 2'b00;
    logic [1:0] reload = 2'b00;
    logic       cpu_cs_n = 1'b1, cpu_clk = 1'b0, cpu_di = 1'b0;
    logic [7:0] img [4];
    int         tick = 0;
    int         checks = 0, errors = 0;

    always #71 clk = ~clk;
    always @(posedge clk) tick++;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        logic [23:0] o0, o1;
        o0 = a - 24'h010000;
        o1 = a - 24'h2ABC00;
        if (o0 < 24'd4) return img[o0[1:0]];
        if (o1 < 24'd4) return img[o1[1:0]];
        return 8'h00;
    endfunction

    function automatic logic flash_bit(input logic [23:0] start, input int n);
        logic [7:0] b;
        b = flash_byte(start + 24'(n / 8));
        return b[7 - (n % 8)];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam logic [18:0] SB = (g == 0) ? 19'h00000 : 19'h7FFFE;
        localparam logic [23:0] FB = (g == 0) ? 24'h010000 : 24'h2ABC00;
        logic        cs_n, sclk, di, req, done, hold;
        logic        fdo = 1'b0, ack = 1'b0;
        logic [18:0] addr;
        logic [7:0]  data;
        int          ack_delay = 0;
        bit          stray = 1'b0;
        int          bitn = 0, cs_falls = 0, di_rx_high = 0, wcnt = 0, wait_cnt = 0;
        int          hold_err = 0, stretch_err = 0;
        logic [31:0] cmd = '0, cmd_last = '0;
        logic        sclk_prev = 1'b0, cs_prev = 1'b1, req_prev = 1'b0;
        logic [18:0] addr_prev = '0;
        logic [7:0]  data_prev = '0;
        logic [18:0] w_addr [256];
        logic [7:0]  w_data [256];

        flash_boot_loader #(.FLASH_BASE(FB), .SRAM_BASE(SB), .LENGTH(4)) dut (
            .clk(clk), .rst_n(rst_n[g]), .reload(reload[g]),
            .cpu_flash_cs_n(cpu_cs_n), .cpu_flash_clk(cpu_clk), .cpu_flash_di(cpu_di),
            .flash_cs_n(cs_n), .flash_clk(sclk), .flash_di(di), .flash_do(fdo),
            .mem_wr_req(req), .mem_addr(addr), .mem_data(data), .mem_wr_ack(ack),
            .boot_done(done), .cpu_hold(hold));

        always @(negedge clk) begin
            // SRAM arbiter: grant after ack_delay waiting cycles, log the write
            ack = 1'b0;
            if (req) begin
                if (req_prev && (addr !== addr_prev || data !== data_prev)) hold_err++;
                if (sclk || cs_n) stretch_err++;
                if (wait_cnt >= ack_delay) begin
                    ack = 1'b1;
                    w_addr[wcnt % 256] = addr;
                    w_data[wcnt % 256] = data;
                    wcnt++;
                    wait_cnt = 0;
                end else wait_cnt++;
            end else begin
                wait_cnt = 0;
                if (stray) ack = 1'b1;
            end
            req_prev = req; addr_prev = addr; data_prev = data;
            // SPI flash: capture command on SCLK rise, present data after SCLK fall
            if (cs_n || done) bitn = 0;
            else begin
                if (sclk && !sclk_prev) begin
                    if (bitn < 32) cmd = {cmd[30:0], di};
                    else if (di) di_rx_high++;
                    bitn++;
                    if (bitn == 32) cmd_last = cmd;
                end
                if (!sclk && sclk_prev && bitn >= 32) fdo = flash_bit(cmd_last[23:0], bitn - 32);
            end
            if (!cs_n && cs_prev && !done) cs_falls++;
            cs_prev = cs_n; sclk_prev = sclk;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    int t0, w0, cf0, dh0, he0, se0;

    task automatic check_reset0(input string name);
        chk({name, "_pins"}, {g_inst[0].cs_n, g_inst[0].sclk, g_inst[0].di, g_inst[0].req,
                              g_inst[0].done, g_inst[0].hold}, 6'b100001);
        chk({name, "_addr"}, g_inst[0].addr, 19'h00000);
        chk({name, "_data"}, g_inst[0].data, 8'h00);
    endtask

    task automatic snap0();
        t0 = tick; w0 = g_inst[0].wcnt; cf0 = g_inst[0].cs_falls;
        dh0 = g_inst[0].di_rx_high; he0 = g_inst[0].hold_err; se0 = g_inst[0].stretch_err;
    endtask

    task automatic start0(input string name);
        rst_n[0] = 1'b0;
        @(negedge clk);
        check_reset0(name);
        @(negedge clk);
        snap0();
        rst_n[0] = 1'b1;
    endtask

    task automatic wait_done0(input int expc, input string name);
        int guard = 0;
        while (!g_inst[0].done && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk({name, "_cycles"}, 64'(tick - t0), 64'(expc));
    endtask

    task automatic check_copy0(input string name);
        chk({name, "_wcount"}, 64'(g_inst[0].wcnt - w0), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk({name, "_addr"}, g_inst[0].w_addr[(w0 + i) % 256], 64'(19'(19'h00000 + i)));
            chk({name, "_data"}, g_inst[0].w_data[(w0 + i) % 256], img[i]);
        end
        chk({name, "_cmd"}, g_inst[0].cmd_last, {8'h03, 24'h010000});
        chk({name, "_csfalls"}, 64'(g_inst[0].cs_falls - cf0), 64'd1);
        chk({name, "_rxdi"}, 64'(g_inst[0].di_rx_high - dh0), 64'd0);
        chk({name, "_hold"}, 64'(g_inst[0].hold_err - he0), 64'd0);
        chk({name, "_stretch"}, 64'(g_inst[0].stretch_err - se0), 64'd0);
        chk({name, "_pads"}, {g_inst[0].cs_n, g_inst[0].sclk, g_inst[0].di, g_inst[0].hold},
            {cpu_cs_n, cpu_clk, cpu_di, 1'b0});
    endtask

    typedef struct {
        int          delay;
        logic [31:0] image;
        bit          stray;
        int          exp_cycles;
    } vec_t;

    vec_t vt [6];

    initial begin
        vt[0] = '{delay: 0, image: 32'hA55AFF00, stray: 1'b0, exp_cycles: 133};
        vt[1] = '{delay: 5, image: 32'hA55AFF00, stray: 1'b0, exp_cycles: 153};
        vt[2] = '{delay: 2, image: 32'h12345678, stray: 1'b1, exp_cycles: 141};
        for (int k = 3; k < 6; k++) begin
            vt[k].delay = $urandom_range(0, 7);
            vt[k].image = $urandom;
            vt[k].stray = 1'($urandom_range(0, 1));
            vt[k].exp_cycles = 1 + 64 + 4 * (16 + 1 + vt[k].delay);
        end
        repeat (3) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) img[i] = vt[k].image[31 - 8 * i -: 8];
            g_inst[0].ack_delay = vt[k].delay;
            g_inst[0].stray = vt[k].stray;
            // CPU-side pins carry noise during the copy; they must be ignored
            cpu_cs_n = 1'($urandom); cpu_clk = 1'($urandom); cpu_di = 1'($urandom);
            start0($sformatf("v%0d_rst", k));
            wait_done0(vt[k].exp_cycles, $sformatf("v%0d", k));
            check_copy0($sformatf("v%0d", k));
        end
        g_inst[0].stray = 1'b0;
        g_inst[0].ack_delay = 0;
        img[0] = 8'hA5; img[1] = 8'h5A; img[2] = 8'hFF; img[3] = 8'h00;
        cpu_cs_n = 1'b1; cpu_clk = 1'b0; cpu_di = 1'b0;

        // asynchronous reset in the middle of byte 2 reception
        start0("rstmid_pre");
        repeat (88) @(negedge clk);
        chk("rstmid_wcount", 64'(g_inst[0].wcnt - w0), 64'd1);
        #2 rst_n[0] = 1'b0;
        #1 check_reset0("rstmid_async");
        @(negedge clk);
        snap0();
        rst_n[0] = 1'b1;
        wait_done0(133, "rstmid");
        check_copy0("rstmid");

        // reload pulses mid-copy are ignored
        start0("rldmid_pre");
        repeat (40) @(negedge clk);
        reload[0] = 1'b1; @(negedge clk); reload[0] = 1'b0;
        repeat (50) @(negedge clk);
        reload[0] = 1'b1; @(negedge clk); reload[0] = 1'b0;
        wait_done0(133, "rldmid");
        check_copy0("rldmid");

        // handover: pads follow the CPU block, loader never requests SRAM
        for (int c = 0; c < 8; c++) begin
            {cpu_cs_n, cpu_clk, cpu_di} = (c == 0) ? 3'b011 : 3'($urandom);
            @(negedge clk);
            chk("cpu_pads", {g_inst[0].cs_n, g_inst[0].sclk, g_inst[0].di, g_inst[0].req},
                {cpu_cs_n, cpu_clk, cpu_di, 1'b0});
        end
        cpu_cs_n = 1'b1; cpu_clk = 1'b0; cpu_di = 1'b0;

        // reload in DONE: boot_done drops on the reload edge, full copy repeats
        snap0();
        reload[0] = 1'b1;
        @(negedge clk);
        reload[0] = 1'b0;
        chk("rlddone_drop", {g_inst[0].done, g_inst[0].hold}, 2'b01);
        wait_done0(134, "rlddone");
        check_copy0("rlddone");

        // second instance: SRAM address wraps modulo 2^19
        begin
            int tb0, wb0, guard;
            tb0 = tick; wb0 = g_inst[1].wcnt; guard = 0;
            rst_n[1] = 1'b1;
            while (!g_inst[1].done && guard < 3000) begin
                @(negedge clk);
                guard++;
            end
            chk("wrap_cycles", 64'(tick - tb0), 64'd133);
            chk("wrap_wcount", 64'(g_inst[1].wcnt - wb0), 64'd4);
            for (int i = 0; i < 4; i++) begin
                chk("wrap_addr", g_inst[1].w_addr[(wb0 + i) % 256], 64'(19'(19'h7FFFE + i)));
                chk("wrap_data", g_inst[1].w_data[(wb0 + i) % 256], img[i]);
            end
            chk("wrap_cmd", g_inst[1].cmd_last, {8'h03, 24'h2ABC00});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
